aes_spi_frame_slave: RTL and testbench

Parametrised successor to the AES SPI slave front end. Shifts a 128-bit block plus an NK*32-bit key in serially on simo, launches an external AES core with a start/done handshake, then shifts the 128-bit result back out on somi. It adds chip-select framing, a selectable key length (AES-128/192/256), selectable bit order, abort detection and result readback, none of which the previous slave has. One serial bit is transferred per clk edge while cs_n is low.

---
 rtl/aes_spi_pkg.sv | 21 ++
 rtl/spi_shift_reg.sv | 35 +++
 rtl/aes_spi_frame_slave.sv | 135 +++++++++++++
 tb/tb_aes_spi_frame_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the framed AES SPI slave.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_MSG,
        RX_KEY,
        WAIT_CORE,
        TX_READY,
        TX_OUT
    } state_t;

    localparam int BLK_W     = 128;
    localparam int KEY_W_MAX = 256;

    // Key length in bits for a key of nk 32-bit words.
    function automatic int key_bits(input int nk);
        return nk * 32;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Bit-addressed capture register for one serial field. A serial index is
// mapped to a register bit (mirrored when MSB_FIRST); the same mapped index
// drives the read port, and the whole register can be parallel-loaded.
module spi_shift_reg #(
    parameter int W         = 128,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IW        = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [IW-1:0] idx,
    input  logic          din,
    input  logic          ld_en,
    input  logic [W-1:0]  ld_data,
    output logic [W-1:0]  q,
    output logic          dout
);

    logic [IW-1:0] pos;

    assign pos  = MSB_FIRST ? (IW'(W - 1) - idx) : idx;
    assign dout = q[pos];

    // Parallel load wins over a serial write; the two never coincide in use.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (ld_en)
            q <= ld_data;
        else if (wr_en)
            q[pos] <= din;
    end

endmodule

// File: rtl/aes_spi_frame_slave.sv
// Framed SPI front end for an external AES core: receives block + key,
// launches the core, then streams the 128-bit result back out on somi.
module aes_spi_frame_slave #(
    parameter int NK        = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter int BLK_W     = 128
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cs_n,
    input  logic                                simo,
    input  logic                                mode,
    output logic                                somi,
    output logic                                core_start,
    output logic [BLK_W-1:0]                    core_msg,
    output logic [aes_spi_pkg::KEY_W_MAX-1:0]   core_key,
    output logic                                core_mode,
    input  logic                                core_done,
    input  logic [BLK_W-1:0]                    core_result,
    output logic                                busy,
    output logic                                frame_err
);

    import aes_spi_pkg::*;

    localparam int KW  = key_bits(NK);
    localparam int KIW = $clog2(KW);
    localparam int MIW = $clog2(BLK_W);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_spi_frame_slave: NK must be 4, 6 or 8");
    end
    if (BLK_W != aes_spi_pkg::BLK_W) begin : g_bad_blk
        $error("aes_spi_frame_slave: BLK_W must be 128");
    end

    state_t          state;
    logic [8:0]      cnt;
    logic            msg_we;
    logic            key_we;
    logic            res_ld;
    logic            res_bit;
    logic [KW-1:0]   key_q;
    logic [BLK_W-1:0] res_q_unused;
    logic            msg_bit_unused;
    logic            key_bit_unused;

    // The first IDLE edge already carries message bit 0 (cnt is 0 in IDLE).
    assign msg_we = !cs_n && (state == IDLE || state == RX_MSG);
    assign key_we = !cs_n && (state == RX_KEY);
    // A done coinciding with our own start pulse belongs to no request of ours.
    assign res_ld = core_done && (state == WAIT_CORE) && !core_start;
    assign busy   = (state != IDLE);
    assign core_key = KEY_W_MAX'(key_q);

    spi_shift_reg #(.W(BLK_W), .MSB_FIRST(MSB_FIRST)) u_msg (
        .clk(clk), .reset(reset), .wr_en(msg_we), .idx(cnt[MIW-1:0]),
        .din(simo), .ld_en(1'b0), .ld_data('0), .q(core_msg), .dout(msg_bit_unused)
    );

    spi_shift_reg #(.W(KW), .MSB_FIRST(MSB_FIRST)) u_key (
        .clk(clk), .reset(reset), .wr_en(key_we), .idx(cnt[KIW-1:0]),
        .din(simo), .ld_en(1'b0), .ld_data('0), .q(key_q), .dout(key_bit_unused)
    );

    spi_shift_reg #(.W(BLK_W), .MSB_FIRST(MSB_FIRST)) u_res (
        .clk(clk), .reset(reset), .wr_en(1'b0), .idx(cnt[MIW-1:0]),
        .din(1'b0), .ld_en(res_ld), .ld_data(core_result), .q(res_q_unused), .dout(res_bit)
    );

    // Frame sequencer: every path back to IDLE clears cnt so the next frame
    // starts at bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            somi       <= 1'b0;
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (!cs_n) begin
                    core_mode <= mode;
                    cnt       <= 9'd1;
                    state     <= RX_MSG;
                end
                RX_MSG: if (cs_n) begin
                    frame_err <= 1'b1;
                    cnt       <= '0;
                    state     <= IDLE;
                end else if (cnt == 9'(BLK_W - 1)) begin
                    cnt   <= '0;
                    state <= RX_KEY;
                end else begin
                    cnt <= cnt + 9'd1;
                end
                RX_KEY: if (cs_n) begin
                    frame_err <= 1'b1;
                    cnt       <= '0;
                    state     <= IDLE;
                end else if (cnt == 9'(KW - 1)) begin
                    core_start <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT_CORE;
                end else begin
                    cnt <= cnt + 9'd1;
                end
                WAIT_CORE: if (res_ld) state <= TX_READY;
                TX_READY: if (!cs_n) begin
                    somi  <= res_bit;
                    cnt   <= 9'd1;
                    state <= TX_OUT;
                end
                TX_OUT: if (cs_n || cnt == 9'(BLK_W)) begin
                    frame_err <= cs_n;
                    somi      <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end else begin
                    somi <= res_bit;
                    cnt  <= cnt + 9'd1;
                end
                default: begin
                    somi  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_spi_frame_slave.sv
// Directed bench: three slaves (NK=4 LSB-first, NK=8 LSB-first,
// NK=6 MSB-first) driven one at a time from shared data lines.
module tb_aes_spi_frame_slave;

    localparam logic [127:0] M1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] M2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R2 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] M3 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [191:0] K3 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] R3 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] K4 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         simo, mode, core_done;
    logic [127:0] core_result;
    logic         cs_n       [3];
    logic         somi       [3];
    logic         core_start [3];
    logic         core_mode  [3];
    logic         busy       [3];
    logic         frame_err  [3];
    logic [127:0] core_msg   [3];
    logic [255:0] core_key   [3];

    int n_chk = 0;
    int n_bad = 0;
    int n_start [3] = '{0, 0, 0};
    int n_ferr  [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    aes_spi_frame_slave #(.NK(4), .MSB_FIRST(1'b0)) u_nk4 (
        .clk(clk), .reset(reset), .cs_n(cs_n[0]), .simo(simo), .mode(mode),
        .somi(somi[0]), .core_start(core_start[0]), .core_msg(core_msg[0]),
        .core_key(core_key[0]), .core_mode(core_mode[0]), .core_done(core_done),
        .core_result(core_result), .busy(busy[0]), .frame_err(frame_err[0])
    );

    aes_spi_frame_slave #(.NK(8), .MSB_FIRST(1'b0)) u_nk8 (
        .clk(clk), .reset(reset), .cs_n(cs_n[1]), .simo(simo), .mode(mode),
        .somi(somi[1]), .core_start(core_start[1]), .core_msg(core_msg[1]),
        .core_key(core_key[1]), .core_mode(core_mode[1]), .core_done(core_done),
        .core_result(core_result), .busy(busy[1]), .frame_err(frame_err[1])
    );

    aes_spi_frame_slave #(.NK(6), .MSB_FIRST(1'b1)) u_nk6m (
        .clk(clk), .reset(reset), .cs_n(cs_n[2]), .simo(simo), .mode(mode),
        .somi(somi[2]), .core_start(core_start[2]), .core_msg(core_msg[2]),
        .core_key(core_key[2]), .core_mode(core_mode[2]), .core_done(core_done),
        .core_result(core_result), .busy(busy[2]), .frame_err(frame_err[2])
    );

    // Pulse counters for start and abort strobes.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (core_start[k]) n_start[k] <= n_start[k] + 1;
            if (frame_err[k])  n_ferr[k]  <= n_ferr[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full inbound frame; mode is toggled after bit 0 to prove single sampling.
    // Ends with cs_n raised, at the negedge where core_start must be high.
    task automatic send_frame(input int s, input logic [127:0] m, input logic [255:0] k,
                              input int kw, input bit msb, input bit md, input string tag);
        int base;
        base = n_start[s];
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            cs_n[s] = 1'b0;
            simo    = msb ? m[127-i] : m[i];
            mode    = (i == 0) ? md : ~md;
        end
        for (int j = 0; j < kw; j++) begin
            @(negedge clk);
            simo = msb ? k[kw-1-j] : k[j];
        end
        @(negedge clk);
        cs_n[s] = 1'b1;
        simo    = 1'b0;
        chk({tag, "_start"}, core_start[s], 1'b1);
        chk({tag, "_noearly"}, n_start[s], base);
        chk({tag, "_msg"}, core_msg[s], m);
        chk({tag, "_key"}, core_key[s], k);
        chk({tag, "_mode"}, core_mode[s], md);
    endtask

    task automatic core_reply(input int d, input logic [127:0] res);
        repeat (d) @(negedge clk);
        core_done   = 1'b1;
        core_result = res;
        @(negedge clk);
        core_done   = 1'b0;
        core_result = '0;
    endtask

    // Reads nb result bits; a complete read also checks the return to IDLE.
    task automatic read_result(input int s, input logic [127:0] exp, input bit msb,
                               input int nb, input string tag);
        logic [127:0] got, want;
        int           p;
        got  = '0;
        want = '0;
        @(negedge clk);
        cs_n[s] = 1'b0;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            p       = msb ? 127 - k : k;
            got[p]  = somi[s];
            want[p] = exp[p];
        end
        chk({tag, "_rd"}, got, want);
        if (nb == 128) begin
            @(negedge clk);
            chk({tag, "_somi_end"}, somi[s], 1'b0);
            chk({tag, "_idle_end"}, busy[s], 1'b0);
            cs_n[s] = 1'b1;
        end
    endtask

    initial begin
        logic [127:0] part;
        int           fe;

        reset = 1'b1; simo = 1'b0; mode = 1'b0; core_done = 1'b0; core_result = '0;
        for (int k = 0; k < 3; k++) cs_n[k] = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_somi", somi[k], 1'b0);
            chk("rst_busy", busy[k], 1'b0);
            chk("rst_start", core_start[k], 1'b0);
            chk("rst_ferr", frame_err[k], 1'b0);
            chk("rst_msg", core_msg[k], '0);
            chk("rst_key", core_key[k], '0);
            chk("rst_mode", core_mode[k], 1'b0);
        end
        reset = 1'b0;

        // 1: AES-128 LSB first; a done in the start cycle must be ignored.
        send_frame(0, M1, {128'h0, K1}, 128, 1'b0, 1'b0, "t1");
        core_done = 1'b1; core_result = 128'hdead;
        @(negedge clk);
        core_done = 1'b0; core_result = '0;
        chk("t1_busy_wait", busy[0], 1'b1);
        core_reply(3, R1);
        chk("t1_start_once", n_start[0], 1);
        read_result(0, R1, 1'b0, 128, "t1");

        // 2: AES-256, 384 inbound bits.
        send_frame(1, M2, K2, 256, 1'b0, 1'b1, "t2");
        core_reply(5, R2);
        chk("t2_start_once", n_start[1], 1);
        read_result(1, R2, 1'b0, 128, "t2");

        // 3: AES-192 MSB first, mirrored readback.
        send_frame(2, M3, {64'h0, K3}, 192, 1'b1, 1'b0, "t3");
        chk("t3_msg127", core_msg[2][127], M3[127]);
        core_reply(2, R3);
        read_result(2, R3, 1'b1, 128, "t3");

        // 4: abort after 100 message bits, then a clean frame.
        fe = n_ferr[0];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cs_n[0] = 1'b0;
            simo    = M2[i];
        end
        @(negedge clk);
        cs_n[0] = 1'b1;
        @(negedge clk);
        chk("t4_ferr_hi", frame_err[0], 1'b1);
        chk("t4_idle", busy[0], 1'b0);
        @(negedge clk);
        chk("t4_ferr_lo", frame_err[0], 1'b0);
        chk("t4_ferr_cnt", n_ferr[0], fe + 1);
        chk("t4_nostart", n_start[0], 1);
        part = M1;
        part[99:0] = M2[99:0];
        chk("t4_partial", core_msg[0], part);
        send_frame(0, M2, {128'h0, K4}, 128, 1'b0, 1'b1, "t4");
        core_reply(1, R4);
        read_result(0, R4, 1'b0, 128, "t4");

        // 5: master deselects while the core takes 50 cycles.
        fe = n_ferr[0];
        send_frame(0, M1, {128'h0, K1}, 128, 1'b0, 1'b0, "t5");
        repeat (25) @(negedge clk);
        chk("t5_busy_mid", busy[0], 1'b1);
        core_reply(25, R1);
        repeat (10) @(negedge clk);
        chk("t5_busy_ready", busy[0], 1'b1);
        chk("t5_somi_ready", somi[0], 1'b0);
        chk("t5_noferr", n_ferr[0], fe);
        read_result(0, R1, 1'b0, 128, "t5");

        // 6: reset in the middle of readback, then a stray done in IDLE.
        send_frame(0, M2, {128'h0, K4}, 128, 1'b0, 1'b1, "t6");
        core_reply(2, R4);
        read_result(0, R4, 1'b0, 60, "t6");
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        cs_n[0] = 1'b1;
        chk("t6_somi", somi[0], 1'b0);
        chk("t6_busy", busy[0], 1'b0);
        chk("t6_start", core_start[0], 1'b0);
        chk("t6_ferr", frame_err[0], 1'b0);
        chk("t6_msg", core_msg[0], '0);
        chk("t6_key", core_key[0], '0);
        chk("t6_mode", core_mode[0], 1'b0);
        core_done = 1'b1; core_result = '1;
        @(negedge clk);
        core_done = 1'b0; core_result = '0;
        chk("t6_stray_busy", busy[0], 1'b0);
        @(negedge clk);
        chk("t6_stray_busy2", busy[0], 1'b0);
        chk("t6_stray_somi", somi[0], 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
